matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/tpu_pkg.sv | 17 +
 rtl/seq_counter.sv | 31 +++
 rtl/matmul_sequencer.sv | 178 +++++++++++++++++
 tb/tb_matmul_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: address width, counter width and the sequencer state type.
package tpu_pkg;

  localparam int ADDR_W = 13;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_I,
    ST_COMPUTE,
    ST_DRAIN,
    ST_STORE,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/seq_counter.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module seq_counter
  import tpu_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of the order of statements or blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/matmul_sequencer.sv
// Command sequencer for the matrix unit: load weights, load inputs, compute, drain, store.
// Optional SEQ_PERF_CNT_EN adds perf_cycles, the accept-to-done cycle count of the last command.
module matmul_sequencer
  import tpu_pkg::*;
#(
  parameter int COMPUTE_CYCLES = 4,
  parameter int DRAIN_TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_weight_addr,
  input  logic [ADDR_W-1:0] cmd_input_addr,
  input  logic [ADDR_W-1:0] cmd_out_addr,
  input  logic              acc1_full,
  input  logic              acc2_full,
  output logic              load_weight,
  output logic              load_input,
  output logic              valid,
  output logic              store,
  output logic [ADDR_W-1:0] base_address,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  seq_state_t state, state_next;

  logic [ADDR_W-1:0] weight_addr, input_addr, out_addr;
  logic              f1, f2;
  logic              accept;
  logic              error_set;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_load_value;
  logic              full_cond;

  // A flag raised in the same cycle it is checked still counts.
  assign full_cond = (f1 | acc1_full) & (f2 | acc2_full);

  // One counter times both phases: loaded with COMPUTE length on entry to
  // COMPUTE, then reloaded with the drain timeout on entry to DRAIN.
  seq_counter #(.W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    error_set      = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = ST_LOAD_W;
        end
      end
      ST_LOAD_W: state_next = ST_LOAD_I;
      ST_LOAD_I: begin
        cnt_load       = 1'b1;
        cnt_load_value = CNT_W'(COMPUTE_CYCLES - 1);
        state_next     = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (cnt_zero) begin
          cnt_load       = 1'b1;
          cnt_load_value = CNT_W'(DRAIN_TIMEOUT - 1);
          state_next     = ST_DRAIN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (full_cond) begin
          state_next = ST_STORE;
        end else if (cnt_zero) begin
          error_set  = 1'b1;
          state_next = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_STORE: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = (state == ST_IDLE);
    busy         = (state != ST_IDLE);
    done         = (state == ST_DONE);
    load_weight  = (state == ST_LOAD_W);
    load_input   = (state == ST_LOAD_I);
    valid        = (state == ST_COMPUTE) || (state == ST_DRAIN);
    store        = (state == ST_STORE);
    base_address = '0;
    case (state)
      ST_LOAD_W:           base_address = weight_addr;
      ST_LOAD_I,
      ST_COMPUTE,
      ST_DRAIN:            base_address = input_addr;
      ST_STORE:            base_address = out_addr;
      default:             base_address = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      weight_addr <= '0;
      input_addr  <= '0;
      out_addr    <= '0;
      f1          <= 1'b0;
      f2          <= 1'b0;
      error       <= 1'b0;
    end else if (accept) begin
      weight_addr <= cmd_weight_addr;
      input_addr  <= cmd_input_addr;
      out_addr    <= cmd_out_addr;
      f1          <= 1'b0;
      f2          <= 1'b0;
      error       <= 1'b0;
    end else begin
      if (state == ST_COMPUTE || state == ST_DRAIN) begin
        f1 <= f1 | acc1_full;
        f2 <= f2 | acc2_full;
      end
      if (error_set) begin
        error <= 1'b1;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] perf_run;

  // perf_run counts the accept cycle onward; the DONE cycle itself is added
  // when the result is latched at the end of DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_run    <= '0;
      perf_cycles <= '0;
    end else begin
      if (accept) begin
        perf_run <= 16'd1;
      end else if (state != ST_IDLE && perf_run != 16'hFFFF) begin
        perf_run <= perf_run + 16'd1;
      end
      if (state == ST_DONE) begin
        perf_cycles <= (perf_run == 16'hFFFF) ? 16'hFFFF : perf_run + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: directed scenarios plus randomized commands
// compared cycle by cycle against a timeline model derived from the sequencing rules.
module tb_matmul_sequencer;

  localparam int C    = 4;
  localparam int TO   = 16;
  localparam int NONE = 100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [12:0] cmd_weight_addr, cmd_input_addr, cmd_out_addr;
  logic        acc1_full, acc2_full;
  logic        load_weight, load_input, valid, store;
  logic [12:0] base_address;
  logic        busy, done, error;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] perf_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  matmul_sequencer #(.COMPUTE_CYCLES(C), .DRAIN_TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_weight_addr (cmd_weight_addr),
    .cmd_input_addr  (cmd_input_addr),
    .cmd_out_addr    (cmd_out_addr),
    .acc1_full       (acc1_full),
    .acc2_full       (acc2_full),
    .load_weight     (load_weight),
    .load_input      (load_input),
    .valid           (valid),
    .store           (store),
    .base_address    (base_address),
    .busy            (busy),
    .done            (done),
    .error           (error)
`ifdef SEQ_PERF_CNT_EN
    ,
    .perf_cycles     (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Timeline model, offsets relative to the accept cycle (offset 0).
  // A flag pulse only counts once COMPUTE has started (offset >= 3).
  task automatic model(input int a1, input int a2,
                       output int d, output bit err, output int done_off);
    int ds, t1, t2, ex;
    ds = 3 + C;
    t1 = (a1 >= 3) ? a1 : NONE;
    t2 = (a2 >= 3) ? a2 : NONE;
    ex = (t1 > t2) ? t1 : t2;
    if (ex < ds) ex = ds;
    if (ex <= ds + TO - 1) begin
      d = ex - ds + 1; err = 1'b0; done_off = ex + 2;
    end else begin
      d = TO; err = 1'b1; done_off = ds + TO;
    end
  endtask

  // Entered and left at a negedge with the DUT in IDLE. hold keeps cmd_valid
  // high throughout and presents the next command's addresses while busy.
  task automatic run_cmd(input string name, input logic [12:0] w, input logic [12:0] i,
                         input logic [12:0] o, input int a1, input int a2, input bit hold,
                         input logic [12:0] nw, input logic [12:0] ni, input logic [12:0] no);
    int d, done_off, ds;
    bit err;
    logic [6:0]  exp_ctrl;
    logic [12:0] exp_base;
    bit          chk_base;
    model(a1, a2, d, err, done_off);
    ds = 3 + C;
    for (int k = 0; k <= done_off; k++) begin
      cmd_valid       = (k == 0) ? 1'b1 : hold;
      cmd_weight_addr = (k == 0) ? w : (hold ? nw : 13'($urandom));
      cmd_input_addr  = (k == 0) ? i : (hold ? ni : 13'($urandom));
      cmd_out_addr    = (k == 0) ? o : (hold ? no : 13'($urandom));
      acc1_full       = (k == a1);
      acc2_full       = (k == a2);
      exp_ctrl = {k == 0, k == 1, k == 2, (k >= 3 && k <= ds + d - 1),
                  (!err && k == ds + d), k != 0, k == done_off};
      check($sformatf("%s ctrl@%0d", name, k),
            {load_weight, load_input, valid, store, busy, done} | (32'(cmd_ready) << 6),
            32'(exp_ctrl));
      chk_base = 1'b1;
      exp_base = '0;
      if (k == 1) exp_base = w;
      else if (k >= 2 && k < ds) exp_base = i;
      else if (k >= ds && k < ds + d) chk_base = 1'b0;
      else if (!err && k == ds + d) exp_base = o;
      if (chk_base) check($sformatf("%s base@%0d", name, k), 32'(base_address), 32'(exp_base));
      if (k == 1) check($sformatf("%s err_clear", name), 32'(error), 32'd0);
      if (k == done_off) check($sformatf("%s error", name), 32'(error), 32'(err));
      @(posedge clk);
      @(negedge clk);
    end
    acc1_full = 1'b0;
    acc2_full = 1'b0;
`ifdef SEQ_PERF_CNT_EN
    check($sformatf("%s perf", name), 32'(perf_cycles), 32'(done_off + 1));
`endif
    check($sformatf("%s err_hold", name), 32'(error), 32'(err));
  endtask

  initial begin
    int a1, a2;
    logic [12:0] w, i, o;
    reset = 1'b1; cmd_valid = 1'b0; acc1_full = 1'b0; acc2_full = 1'b0;
    cmd_weight_addr = '0; cmd_input_addr = '0; cmd_out_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset ctrl", {25'd0, cmd_ready, load_weight, load_input, valid, store, busy, done},
          32'h40);
    check("reset base", 32'(base_address), 32'd0);
    check("reset error", 32'(error), 32'd0);
`ifdef SEQ_PERF_CNT_EN
    check("reset perf", 32'(perf_cycles), 32'd0);
`endif

    // Both fulls in first DRAIN cycle: done at T+9, perf 10.
    run_cmd("basic", 13'h010, 13'h020, 13'h030, 3 + C, 3 + C, 1'b0, '0, '0, '0);
    // acc1 during COMPUTE, acc2 three cycles into DRAIN.
    run_cmd("late2", 13'h111, 13'h222, 13'h333, 4, 3 + C + 3, 1'b0, '0, '0, '0);
    // No fulls: drain timeout with error, then cleared by next accept.
    run_cmd("timeout", 13'h0AA, 13'h0BB, 13'h0CC, -1, -1, 1'b0, '0, '0, '0);
    run_cmd("after_to", 13'h1AA, 13'h1BB, 13'h1CC, 3 + C, 3 + C + 1, 1'b0, '0, '0, '0);
    // Full condition in the final timeout cycle wins.
    run_cmd("tie", 13'h0DE, 13'h0AD, 13'h0BE, 3 + C + TO - 1, 3 + C + TO - 1, 1'b0, '0, '0, '0);
    // Pulse before COMPUTE is ignored, so this times out.
    run_cmd("early", 13'h005, 13'h006, 13'h007, 1, 3 + C, 1'b0, '0, '0, '0);
    // cmd_valid held: back-to-back accepts use the second addresses.
    run_cmd("hold1", 13'h101, 13'h102, 13'h103, 3 + C, 3 + C, 1'b1, 13'h1F1, 13'h1F2, 13'h1F3);
    run_cmd("hold2", 13'h1F1, 13'h1F2, 13'h1F3, 5, 3 + C + 2, 1'b0, '0, '0, '0);

    // Reset in COMPUTE abandons the command.
    cmd_valid = 1'b1; cmd_weight_addr = 13'h044; cmd_input_addr = 13'h055; cmd_out_addr = 13'h066;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("pre_reset valid", 32'(valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset ctrl", {25'd0, cmd_ready, load_weight, load_input, valid, store, busy, done},
          32'h40);
    acc1_full = 1'b1; acc2_full = 1'b1;
    for (int k = 0; k < 24; k++) begin
      check($sformatf("abandon@%0d", k), {30'd0, store, done}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    acc1_full = 1'b0; acc2_full = 1'b0;

    for (int n = 0; n < 30; n++) begin
      w = 13'($urandom); i = 13'($urandom); o = 13'($urandom);
      a1 = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3 + C + TO + 1));
      a2 = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3 + C + TO + 1));
      run_cmd($sformatf("rand%0d", n), w, i, o, a1, a2, 1'b0, '0, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
